mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: AW, 15, memory word-address width.
REQ-002 Parameter: DW, 48, memory data width.
REQ-003 Parameter: TIMEOUT, 255, max cycles waiting for mem_ack before abort (1..255).
REQ-004 The block SHALL have one clock; reset is synchronous and active-low.
REQ-005 Ports SHALL be (name direction width meaning):
- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous reset, active-low (0 = reset)
- req  in  3  request per requester: [0] loader, [1] instruction fetch, [2] operand access
- we  in  3  per-requester write enable
- addr  in  3xAW  per-requester word address
- wdata  in  3xDW  per-requester write data
- ack  out  3  per-requester one-cycle completion pulse
- rdata  out  DW  read data, valid with any ack bit
- err  out  1  timeout indication, valid with ack
- err_sticky  out  1  set on any timeout, cleared only by reset
- mem_req  out  1  memory request, held until mem_ack or abort
- mem_we  out  1  memory write enable
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_ack  in  1  memory completion, one cycle
- mem_rdata  in  DW  memory read data, valid with mem_ack

Function
REQ-006 FSM states SHALL be IDLE, BUSY, RESP.
REQ-007 IDLE: if any req bit is 1, select winner, register its we/addr/wdata onto mem_*, set mem_req=1, go BUSY next edge; else stay IDLE.
REQ-008 Priority: loader (req[0]) SHALL always win; fetch vs operand SHALL alternate round-robin via one last-served bit.
REQ-009 Round-robin bit SHALL update only when fetch or operand is granted; loader grants SHALL NOT change it.
REQ-010 If only one of fetch/operand requests, it SHALL win regardless of the round-robin bit.
REQ-011 mem_we/mem_addr/mem_wdata SHALL stay stable for the whole BUSY period; requester inputs changing during BUSY SHALL be ignored.
REQ-012 BUSY: mem_ack=1 SHALL register mem_rdata into rdata, clear mem_req, go RESP next edge.
REQ-013 BUSY: wait counter counts from 0 each BUSY cycle; reaching TIMEOUT without mem_ack SHALL clear mem_req, set rdata=0, err=1, err_sticky=1, go RESP.
REQ-014 mem_ack in the same cycle the counter reaches TIMEOUT SHALL count as success (err=0).
REQ-015 RESP: exactly one ack bit (the granted requester) SHALL be 1 for one cycle; err valid alongside; return to IDLE.
REQ-016 req sampled only in IDLE; req still high during RESP SHALL NOT start a transaction until the next IDLE cycle.
REQ-017 Latency: req seen in IDLE at edge N -> mem_req high after N; zero-wait mem_ack -> ack high in cycle N+2; peak rate one transaction per 3 cycles.
REQ-018 rdata SHALL hold its last value outside RESP; write transactions SHALL still update rdata from mem_rdata.
REQ-019 mem_ack arriving in IDLE or RESP SHALL be ignored.

Reset
REQ-020 With reset=0 at an edge: state=IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, ack=0, rdata=0, err=0, err_sticky=0, round-robin bit selects fetch first, counter=0.
REQ-021 Reset asserted in BUSY SHALL abort the transaction with no ack issued; mem_req low after that edge.

Structure
REQ-022 Package mem_arb_pkg SHALL hold the state enum (IDLE/BUSY/RESP), requester index constants (REQ_LOAD=0, REQ_FETCH=1, REQ_DATA=2) and default AW/DW.
REQ-023 Watchdog counter SHALL be sub-module mem_arb_timer (inputs clk, reset, run, clear; output expired; parameter TIMEOUT).

Verification
REQ-024 Single read: req=3'b010, addr[1]=15'h0123, mem_ack one cycle after mem_req with mem_rdata=48'hA5A5_0000_FFFF -> mem_addr=0123, mem_we=0, ack=3'b010 with rdata=A5A50000FFFF, err=0.
REQ-025 Contention: req=3'b111 held -> grant order loader, fetch, operand, fetch, operand; loader never displaced while req[0]=1.
REQ-026 Round-robin: req=3'b110 held, zero-wait memory, 4 transactions -> acks 010,100,010,100 at 3-cycle spacing.
REQ-027 Timeout: TIMEOUT=4, mem_ack never asserted -> mem_req high exactly 4 cycles, ack pulse with err=1, rdata=0, err_sticky stays 1 afterward.
REQ-028 Reset mid-BUSY: write in flight, reset=0 for one edge -> mem_req=0, no ack, err_sticky=0; next req=3'b100 granted operand (fetch-first bit only affects contention).
REQ-029 Write: req=3'b001, we=3'b001, addr[0]=15'h7FFF, wdata[0]=48'h0000_0000_0001 -> mem_we=1, mem_addr=7FFF, mem_wdata=1 held stable while requester changes addr during BUSY.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the three-requester memory arbiter.
package mem_arb_pkg;

  localparam int DEF_AW = 15;
  localparam int DEF_DW = 48;

  // Requester slot indices into req/we/addr/wdata/ack.
  localparam logic [1:0] REQ_LOAD  = 2'd0;
  localparam logic [1:0] REQ_FETCH = 2'd1;
  localparam logic [1:0] REQ_DATA  = 2'd2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/mem_arb_timer.sv
// Watchdog for a memory transaction: counts BUSY cycles and flags the
// cycle in which the count would reach TIMEOUT.
module mem_arb_timer #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  input  logic clear,
  output logic expired
);

  logic [7:0] cnt;

  // Restart from zero whenever not waiting; advance once per waiting cycle.
  always_ff @(posedge clk) begin
    if (!reset || clear) begin
      cnt <= '0;
    end else if (run) begin
      cnt <= cnt + 8'd1;
    end
  end

  // The edge closing this cycle is the TIMEOUT-th waiting edge.
  assign expired = run && (cnt == 8'(TIMEOUT - 1));

endmodule

// File: rtl/mem_arbiter.sv
// Three-requester single-port memory arbiter: loader has fixed priority,
// fetch and operand share the port round-robin. Each transaction walks
// IDLE -> BUSY -> RESP, with a watchdog aborting a stalled memory.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW      = DEF_AW,
  parameter int DW      = DEF_DW,
  parameter int TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [2:0]      req,
  input  logic [2:0]      we,
  input  logic [3*AW-1:0] addr,
  input  logic [3*DW-1:0] wdata,
  output logic [2:0]      ack,
  output logic [DW-1:0]   rdata,
  output logic            err,
  output logic            err_sticky,
  output logic            mem_req,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  input  logic            mem_ack,
  input  logic [DW-1:0]   mem_rdata
);

  state_t          state, state_next;
  logic            load_en, done_ok, done_to;
  logic            expired;
  logic            rr_data;      // 1: operand wins the next fetch/operand tie
  logic [2:0]      grant;        // one-hot owner of the current transaction
  logic [1:0]      win_idx;
  logic [2:0]      win;
  logic            sel_we;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_wdata;

  mem_arb_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .run     (state == BUSY),
    .clear   (state != BUSY),
    .expired (expired)
  );

  // Pick the winner and mux its transaction fields.
  always_comb begin
    win_idx = REQ_DATA;
    if (req[REQ_LOAD]) begin
      win_idx = REQ_LOAD;
    end else if (req[REQ_FETCH] && req[REQ_DATA]) begin
      win_idx = rr_data ? REQ_DATA : REQ_FETCH;
    end else if (req[REQ_FETCH]) begin
      win_idx = REQ_FETCH;
    end
    win = 3'(3'b001 << win_idx);
    case (win_idx)
      REQ_FETCH: begin
        sel_we    = we[REQ_FETCH];
        sel_addr  = addr[AW +: AW];
        sel_wdata = wdata[DW +: DW];
      end
      REQ_DATA: begin
        sel_we    = we[REQ_DATA];
        sel_addr  = addr[2*AW +: AW];
        sel_wdata = wdata[2*DW +: DW];
      end
      default: begin
        sel_we    = we[REQ_LOAD];
        sel_addr  = addr[AW-1:0];
        sel_wdata = wdata[DW-1:0];
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and transaction events; mem_ack counts only in BUSY and
  // beats the watchdog when both land in the same cycle.
  always_comb begin
    state_next = state;
    load_en    = 1'b0;
    done_ok    = 1'b0;
    done_to    = 1'b0;
    case (state)
      IDLE: begin
        if (|req) begin
          load_en    = 1'b1;
          state_next = BUSY;
        end
      end
      BUSY: begin
        if (mem_ack) begin
          done_ok    = 1'b1;
          state_next = RESP;
        end else if (expired) begin
          done_to    = 1'b1;
          state_next = RESP;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Memory-side registers, response registers and round-robin bookkeeping.
  always_ff @(posedge clk) begin
    if (!reset) begin
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      grant      <= '0;
      rr_data    <= 1'b0;
      ack        <= '0;
      err        <= 1'b0;
      err_sticky <= 1'b0;
      rdata      <= '0;
    end else begin
      ack <= '0;
      err <= 1'b0;
      if (load_en) begin
        mem_req   <= 1'b1;
        mem_we    <= sel_we;
        mem_addr  <= sel_addr;
        mem_wdata <= sel_wdata;
        grant     <= win;
        if (win_idx == REQ_FETCH) begin
          rr_data <= 1'b1;
        end else if (win_idx == REQ_DATA) begin
          rr_data <= 1'b0;
        end
      end
      if (done_ok) begin
        mem_req <= 1'b0;
        rdata   <= mem_rdata;
        ack     <= grant;
      end
      if (done_to) begin
        mem_req    <= 1'b0;
        rdata      <= '0;
        ack        <= grant;
        err        <= 1'b1;
        err_sticky <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter (TIMEOUT=4) with hand-computed expectations.
module tb_mem_arbiter;

  localparam int AW = 15;
  localparam int DW = 48;

  logic            clk = 1'b0;
  logic            reset;
  logic [2:0]      req;
  logic [2:0]      we;
  logic [3*AW-1:0] addr;
  logic [3*DW-1:0] wdata;
  logic [2:0]      ack;
  logic [DW-1:0]   rdata;
  logic            err;
  logic            err_sticky;
  logic            mem_req;
  logic            mem_we;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic            mem_ack;
  logic [DW-1:0]   mem_rdata;

  int n_cmp = 0;
  int n_bad = 0;
  logic auto_ack;

  mem_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .we         (we),
    .addr       (addr),
    .wdata      (wdata),
    .ack        (ack),
    .rdata      (rdata),
    .err        (err),
    .err_sticky (err_sticky),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock edge; outputs are stable 1ns later. The zero-wait memory
  // answers in the first BUSY cycle when auto_ack is set.
  task automatic tick();
    @(posedge clk);
    #1;
    mem_ack = auto_ack && mem_req;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    req   = '0;
    tick();
    reset = 1'b1;
  endtask

  initial begin
    logic [2:0] exp_tab [6];
    int         loads;
    int         hi;

    reset = 1'b0; req = '0; we = '0; addr = '0; wdata = '0;
    mem_ack = 1'b0; mem_rdata = '0; auto_ack = 1'b0;

    // Reset state
    tick(); tick();
    chk_eq("rst_mem_req", 64'(mem_req), 64'd0);
    chk_eq("rst_mem_we", 64'(mem_we), 64'd0);
    chk_eq("rst_mem_addr", 64'(mem_addr), 64'd0);
    chk_eq("rst_mem_wdata", 64'(mem_wdata), 64'd0);
    chk_eq("rst_ack", 64'(ack), 64'd0);
    chk_eq("rst_rdata", 64'(rdata), 64'd0);
    chk_eq("rst_err", 64'(err), 64'd0);
    chk_eq("rst_sticky", 64'(err_sticky), 64'd0);
    reset = 1'b1;

    // Single read by fetch
    auto_ack  = 1'b1;
    mem_rdata = 48'hA5A5_0000_FFFF;
    req = 3'b010; we = 3'b000; addr[AW +: AW] = 15'h0123;
    tick();
    req = 3'b000;
    chk_eq("rd_mem_req", 64'(mem_req), 64'd1);
    chk_eq("rd_mem_addr", 64'(mem_addr), 64'h0123);
    chk_eq("rd_mem_we", 64'(mem_we), 64'd0);
    chk_eq("rd_busy_ack", 64'(ack), 64'd0);
    tick();
    chk_eq("rd_ack", 64'(ack), 64'b010);
    chk_eq("rd_rdata", 64'(rdata), 64'hA5A5_0000_FFFF);
    chk_eq("rd_err", 64'(err), 64'd0);
    chk_eq("rd_mem_req_low", 64'(mem_req), 64'd0);
    tick();
    chk_eq("rd_ack_done", 64'(ack), 64'd0);
    chk_eq("rd_rdata_hold", 64'(rdata), 64'hA5A5_0000_FFFF);

    // Round-robin fetch/operand from fetch-first
    do_reset();
    req = 3'b110;
    for (int t = 1; t <= 12; t++) begin
      logic [2:0] e;
      tick();
      e = 3'b000;
      if (t == 2 || t == 8) e = 3'b010;
      if (t == 5 || t == 11) e = 3'b100;
      chk_eq($sformatf("rr_t%0d", t), 64'(ack), 64'(e));
    end
    req = 3'b000;
    tick();

    // Contention: loader holds two grants, then fetch/operand alternate
    exp_tab[0] = 3'b001; exp_tab[1] = 3'b001; exp_tab[2] = 3'b010;
    exp_tab[3] = 3'b100; exp_tab[4] = 3'b010; exp_tab[5] = 3'b100;
    loads = 0;
    req = 3'b111;
    for (int t = 1; t <= 18; t++) begin
      logic [2:0] e;
      tick();
      e = (t % 3 == 2) ? exp_tab[t / 3] : 3'b000;
      chk_eq($sformatf("cont_t%0d", t), 64'(ack), 64'(e));
      if (ack[0]) begin
        loads++;
        if (loads == 2) req[0] = 1'b0;
      end
    end
    req = 3'b000;
    tick();

    // Loader write held stable while the requester changes its inputs
    auto_ack = 1'b0;
    req = 3'b001; we = 3'b001;
    addr[AW-1:0]  = 15'h7FFF;
    wdata[DW-1:0] = 48'h0000_0000_0001;
    tick();
    chk_eq("wr_mem_we", 64'(mem_we), 64'd1);
    chk_eq("wr_mem_addr", 64'(mem_addr), 64'h7FFF);
    chk_eq("wr_mem_wdata", 64'(mem_wdata), 64'd1);
    req = 3'b000; we = 3'b000;
    addr[AW-1:0]  = 15'h1234;
    wdata[DW-1:0] = 48'hDEAD_BEEF_0000;
    tick();
    chk_eq("wr_hold_req", 64'(mem_req), 64'd1);
    chk_eq("wr_hold_we", 64'(mem_we), 64'd1);
    chk_eq("wr_hold_addr", 64'(mem_addr), 64'h7FFF);
    chk_eq("wr_hold_wdata", 64'(mem_wdata), 64'd1);
    mem_ack   = 1'b1;
    mem_rdata = 48'h0000_1111_2222;
    tick();
    chk_eq("wr_ack", 64'(ack), 64'b001);
    chk_eq("wr_err", 64'(err), 64'd0);
    chk_eq("wr_rdata", 64'(rdata), 64'h0000_1111_2222);
    tick();

    // Timeout: memory never answers
    req = 3'b100; addr[2*AW +: AW] = 15'h0042;
    tick();
    req = 3'b000;
    hi = 0;
    for (int i = 0; i < 20; i++) begin
      if (!mem_req) break;
      hi++;
      tick();
    end
    chk_eq("to_req_cycles", 64'(hi), 64'd4);
    chk_eq("to_ack", 64'(ack), 64'b100);
    chk_eq("to_err", 64'(err), 64'd1);
    chk_eq("to_rdata", 64'(rdata), 64'd0);
    chk_eq("to_sticky", 64'(err_sticky), 64'd1);
    tick();
    chk_eq("to_ack_done", 64'(ack), 64'd0);
    chk_eq("to_err_done", 64'(err), 64'd0);
    chk_eq("to_sticky_hold", 64'(err_sticky), 64'd1);

    // mem_ack in the expiry cycle is a success
    req = 3'b010;
    tick();
    req = 3'b000;
    tick(); tick(); tick();
    chk_eq("edge_req_still", 64'(mem_req), 64'd1);
    mem_ack   = 1'b1;
    mem_rdata = 48'h1234_5678_9ABC;
    tick();
    chk_eq("edge_ack", 64'(ack), 64'b010);
    chk_eq("edge_err", 64'(err), 64'd0);
    chk_eq("edge_rdata", 64'(rdata), 64'h1234_5678_9ABC);
    tick();

    // Stray mem_ack in IDLE is ignored
    mem_ack   = 1'b1;
    mem_rdata = 48'hFFFF_FFFF_FFFF;
    tick();
    chk_eq("idle_ack", 64'(ack), 64'd0);
    chk_eq("idle_rdata", 64'(rdata), 64'h1234_5678_9ABC);
    chk_eq("idle_mem_req", 64'(mem_req), 64'd0);

    // Reset during a write in flight
    req = 3'b001; we = 3'b001;
    tick();
    chk_eq("mid_busy", 64'(mem_req), 64'd1);
    reset = 1'b0; req = 3'b000; we = 3'b000;
    tick();
    reset = 1'b1;
    chk_eq("mid_mem_req", 64'(mem_req), 64'd0);
    chk_eq("mid_ack", 64'(ack), 64'd0);
    chk_eq("mid_sticky", 64'(err_sticky), 64'd0);
    chk_eq("mid_mem_we", 64'(mem_we), 64'd0);
    tick();
    chk_eq("mid_no_late_ack", 64'(ack), 64'd0);
    auto_ack = 1'b1;
    req = 3'b100; addr[2*AW +: AW] = 15'h0555;
    tick();
    req = 3'b000;
    chk_eq("post_mem_req", 64'(mem_req), 64'd1);
    chk_eq("post_mem_addr", 64'(mem_addr), 64'h0555);
    tick();
    chk_eq("post_ack", 64'(ack), 64'b100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
    $fatal(1);
  end

endmodule
